// File: rtl/pushbutton_in_if.sv
`default_nettype none
// ============================================================================
// Module   : pushbutton_in_if
// Purpose  : Button-conditioner signal bundle between the processor side and
//            the pushbutton_in conditioner.
// Revision : 1.0 - initial release
// ============================================================================
interface pushbutton_in_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] buttons_raw;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] press_evt;
    logic             pending;

    // Processor / board side: drives raw buttons and the read strobe.
    modport master (
        output buttons_raw,
        output rd_en,
        input  data_out,
        input  level,
        input  press_evt,
        input  pending
    );

    // Conditioner side.
    modport slave (
        input  buttons_raw,
        input  rd_en,
        output data_out,
        output level,
        output press_evt,
        output pending
    );
endinterface
`default_nettype wire

// File: rtl/pushbutton_in.sv
`default_nettype none
// ============================================================================
// Module   : pushbutton_in
// Purpose  : Synchronise, debounce and sticky-latch the 4-bit PUSHBUTTONS port
//            ahead of the processor's input bus driver.
// Revision : 1.0 - initial release
// ============================================================================
module pushbutton_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit STICKY          = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    pushbutton_in_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0]            r_sync1;
    logic [WIDTH-1:0]            r_sync2;
    logic [WIDTH-1:0]            r_level;
    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]            r_rise;
    logic [WIDTH-1:0]            r_press_evt;
    logic [WIDTH-1:0]            r_sticky;

    logic [WIDTH-1:0]            w_level_nxt;
    logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]            w_set;
    logic [WIDTH-1:0]            w_sticky_nxt;

    // Per-bit debounce: a level is only accepted after DEBOUNCE_CYCLES
    // consecutive mismatching samples; any match in between restarts the count.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic w_match;
            logic w_accept;

            assign w_match  = (r_sync2[i] == r_level[i]);
            assign w_accept = !w_match && (r_cnt[i] == c_CNT_MAX);

            assign w_level_nxt[i] = w_accept ? r_sync2[i] : r_level[i];
            assign w_cnt_nxt[i]   = (w_match || w_accept) ? '0
                                                          : r_cnt[i] + c_CNT_ONE;
            assign w_set[i]       = w_accept && r_sync2[i];
        end
    endgenerate

    // Set has priority over the read-clear so a press landing on a read is kept.
    assign w_sticky_nxt = w_set | (r_sticky & ~{WIDTH{bus.rd_en}});

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_level     <= '0;
            r_cnt       <= '0;
            r_rise      <= '0;
            r_press_evt <= '0;
            r_sticky    <= '0;
        end else begin
            r_sync1     <= bus.buttons_raw;
            r_sync2     <= r_sync1;
            r_level     <= w_level_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rise      <= w_set;
            r_press_evt <= r_rise;
            r_sticky    <= w_sticky_nxt;
        end
    end

    generate
        if (STICKY) begin : g_out_sticky
            assign bus.data_out = r_sticky;
        end else begin : g_out_level
            assign bus.data_out = r_level;
        end
    endgenerate

    assign bus.level     = r_level;
    assign bus.press_evt = r_press_evt;
    assign bus.pending   = |r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_pushbutton_in
// Purpose  : Directed self-checking bench for pushbutton_in (STICKY=1 and
//            STICKY=0 instances driven with identical stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pushbutton_in;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   press0_cnt;

    pushbutton_in_if #(.WIDTH(4)) bus  ();
    pushbutton_in_if #(.WIDTH(4)) bus0 ();

    assign bus0.buttons_raw = bus.buttons_raw;
    assign bus0.rd_en       = bus.rd_en;

    pushbutton_in #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .STICKY(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    pushbutton_in #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .STICKY(1'b0)) u_dut_lvl (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial press0_cnt = 0;
    always @(negedge clk) if (bus.press_evt[0]) press0_cnt = press0_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_pulse();
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        logic seen;
        int   p0;
        n_checks = 0;
        n_pass   = 0;

        // 1. Reset with all buttons pressed, then release reset.
        reset           = 1'b0;
        bus.buttons_raw = 4'hF;
        bus.rd_en       = 1'b0;
        tick(2);
        check("rst_level",     32'(bus.level),     32'h0);
        check("rst_data_out",  32'(bus.data_out),  32'h0);
        check("rst_pending",   32'(bus.pending),   32'h0);
        check("rst_press_evt", 32'(bus.press_evt), 32'h0);
        reset = 1'b1;
        tick(17);
        check("rst_level_e17", 32'(bus.level), 32'h0);
        tick(1);
        check("rst_level_e18", 32'(bus.level),    32'hF);
        check("rst_sticky_e18", 32'(bus.data_out), 32'hF);
        tick(1);
        check("rst_press_e19", 32'(bus.press_evt), 32'hF);
        check("rst_lvl_build", 32'(bus0.data_out), 32'hF);
        read_pulse();
        bus.buttons_raw = 4'h0;
        tick(18);
        check("rst_release", 32'(bus.level), 32'h0);
        tick(1);
        check("rst_no_rel_evt", 32'(bus.press_evt), 32'h0);

        // 2. Clean press on bit1.
        bus.buttons_raw = 4'b0010;
        tick(17);
        check("press_e17", 32'(bus.level), 32'h0);
        tick(1);
        check("press_level_e18", 32'(bus.level),     32'h2);
        check("press_evt_e18",   32'(bus.press_evt), 32'h0);
        check("press_data_e18",  32'(bus.data_out),  32'h2);
        check("press_pending",   32'(bus.pending),   32'h1);
        tick(1);
        check("press_evt_e19", 32'(bus.press_evt), 32'h2);
        tick(1);
        check("press_evt_e20", 32'(bus.press_evt), 32'h0);
        bus.buttons_raw = 4'b0000;
        tick(18);
        check("press_release",    32'(bus.level),    32'h0);
        check("press_sticky_rel", 32'(bus.data_out), 32'h2);
        tick(1);
        check("press_no_rel_evt", 32'(bus.press_evt), 32'h0);
        read_pulse();
        check("press_cleared", 32'(bus.data_out), 32'h0);

        // 3. Bounce on bit0: runs shorter than the debounce window are rejected.
        p0   = press0_cnt;
        seen = 1'b0;
        bus.buttons_raw = 4'b0001; for (int k = 0; k < 5; k++) begin tick(1); seen |= bus.level[0]; end
        bus.buttons_raw = 4'b0000; for (int k = 0; k < 3; k++) begin tick(1); seen |= bus.level[0]; end
        bus.buttons_raw = 4'b0001; for (int k = 0; k < 9; k++) begin tick(1); seen |= bus.level[0]; end
        bus.buttons_raw = 4'b0000; for (int k = 0; k < 3; k++) begin tick(1); seen |= bus.level[0]; end
        bus.buttons_raw = 4'b0001;
        for (int k = 0; k < 17; k++) begin tick(1); seen |= bus.level[0]; end
        check("bounce_rejected", 32'(seen), 32'h0);
        tick(1);
        check("bounce_accept_e18", 32'(bus.level[0]), 32'h1);
        tick(3);
        check("bounce_one_evt", 32'(press0_cnt - p0), 32'd1);
        bus.buttons_raw = 4'b0000;
        tick(18);
        read_pulse();
        check("bounce_cleanup", 32'(bus.level), 32'h0);

        // 4. Read-clear of sticky 0101, then a harmless second read.
        bus.buttons_raw = 4'b0101;
        tick(18);
        check("rd_sticky_set", 32'(bus.data_out), 32'h5);
        read_pulse();
        check("rd_clear_data", 32'(bus.data_out), 32'h0);
        check("rd_clear_pend", 32'(bus.pending),  32'h0);
        read_pulse();
        check("rd_again_data", 32'(bus.data_out), 32'h0);
        check("rd_level_kept", 32'(bus.level),    32'h5);
        bus.buttons_raw = 4'b0000;
        tick(18);

        // 5. Read coincides with the edge committing bit3 while sticky=0001.
        bus.buttons_raw = 4'b0001;
        tick(18);
        check("sim_sticky0", 32'(bus.data_out), 32'h1);
        bus.buttons_raw = 4'b1001;
        tick(17);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        check("sim_set_wins", 32'(bus.data_out), 32'h8);
        check("sim_level",    32'(bus.level),    32'h9);
        bus.buttons_raw = 4'b0000;
        tick(18);
        read_pulse();
        check("sim_cleanup", 32'(bus.level), 32'h0);

        // 6. Reset in the middle of a bit2 debounce restarts the count.
        bus.buttons_raw = 4'b0100;
        tick(10);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("mid_rst_level", 32'(bus.level),     32'h0);
        check("mid_rst_lvlb",  32'(bus0.data_out), 32'h0);
        tick(8);
        check("mid_rst_not8",  32'(bus.level),     32'h0);
        tick(9);
        check("mid_rst_e17",   32'(bus.level),     32'h0);
        tick(1);
        check("mid_rst_e18",   32'(bus.level),     32'h4);
        check("mid_rst_lvlb18", 32'(bus0.data_out), 32'h4);
        check("mid_rst_pend",  32'(bus0.pending),  32'h1);
        read_pulse();
        check("lvl_rd_ignored", 32'(bus0.data_out), 32'h4);
        check("lvl_rd_pend",    32'(bus0.pending),  32'h0);
        check("stk_rd_clear",   32'(bus.data_out),  32'h0);
        bus.buttons_raw = 4'b0000;
        tick(17);
        check("lvl_rel_e17", 32'(bus0.data_out), 32'h4);
        tick(1);
        check("lvl_rel_e18", 32'(bus0.data_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
